audio_frame_capture: RTL and testbench

- Streaming front end for the audio min/max engine. It accepts one signed sample per valid/ready beat and packs N consecutive samples into a frame buffer.
- When the frame is complete it pulses frame_start, then holds the frame stable until the consumer signals completion.
- It is the writer/initiator side of the frame + start/done interface. Input back-pressure is applied while a frame is held.

---
 rtl/audio_frame_capture.sv | 158 +++++++++++++++
 tb/tb_audio_frame_capture.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/audio_frame_capture.sv
// audio_frame_capture
// Streaming front end for the audio min/max engine. Packs N consecutive
// signed samples (valid/ready) into a frame buffer, pulses frame_start when
// the frame is complete and holds it frozen until the consumer pulses
// frame_done. Input is back-pressured while a frame is held.
//
// Optional feature: define AUDIO_FRAME_CAPTURE_DROP_COUNT_EN to add the
// saturating drop_count output (back-pressured or flush-discarded samples).
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   s_valid/s_data  input sample stream (W-bit two's complement)
//   s_ready         block accepts a sample this cycle
//   flush           discard partial frame, restart at slot 0 (FILL only)
//   frame_data      packed frame, slot 0 = oldest sample at bits [W-1:0]
//   frame_start     one-cycle pulse, frame complete
//   frame_done      one-cycle completion pulse from consumer
//   busy            high from frame_start until frame_done accepted
//   frame_count     acknowledged frames, wraps modulo 2^CW
//   drop_count      (optional) dropped samples, saturating
//
// state      | meaning
// ST_FILL    | accepting samples into slot wr_idx
// ST_HANDOFF | single cycle, frame_start asserted
// ST_WAIT_DONE | frame frozen, waiting for consumer frame_done

module audio_frame_capture #(
   parameter int N  = 100,
   parameter int W  = 32,
   parameter int CW = 16
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           s_valid,
   input  logic [W-1:0]   s_data,
   output logic           s_ready,
   input  logic           flush,
   output logic [N*W-1:0] frame_data,
   output logic           frame_start,
   input  logic           frame_done,
   output logic           busy,
   output logic [CW-1:0]  frame_count
`ifdef AUDIO_FRAME_CAPTURE_DROP_COUNT_EN
   ,
   output logic [CW-1:0]  drop_count
`endif
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      ST_FILL,
      ST_HANDOFF,
      ST_WAIT_DONE
   } state_t;

   state_t         state_q, state_d;
   logic [IW-1:0]  wr_idx_q, wr_idx_d;
   logic [N*W-1:0] frame_q, frame_d;
   logic           s_ready_q, s_ready_d;
   logic           frame_start_q, frame_start_d;
   logic           busy_q, busy_d;
   logic [CW-1:0]  frame_count_q, frame_count_d;
`ifdef AUDIO_FRAME_CAPTURE_DROP_COUNT_EN
   logic [CW-1:0]  drop_count_q, drop_count_d;
`endif

   always_comb begin
      state_d       = state_q;
      wr_idx_d      = wr_idx_q;
      frame_d       = frame_q;
      s_ready_d     = s_ready_q;
      frame_start_d = 1'b0;
      busy_d        = busy_q;
      frame_count_d = frame_count_q;

      unique case (state_q)
         ST_FILL: begin
            // flush wins over a same-cycle beat; slot contents are left alone
            if (flush) begin
               wr_idx_d = '0;
            end else if (s_valid && s_ready_q) begin
               frame_d[wr_idx_q*W +: W] = s_data;
               if (wr_idx_q == IW'(N-1)) begin
                  wr_idx_d      = '0;
                  state_d       = ST_HANDOFF;
                  s_ready_d     = 1'b0;
                  frame_start_d = 1'b1;
                  busy_d        = 1'b1;
               end else begin
                  wr_idx_d = wr_idx_q + IW'(1);
               end
            end
         end
         ST_HANDOFF: begin
            // a done arriving here is too early and is ignored
            state_d = ST_WAIT_DONE;
         end
         ST_WAIT_DONE: begin
            if (frame_done) begin
               frame_count_d = frame_count_q + CW'(1);
               state_d       = ST_FILL;
               s_ready_d     = 1'b1;
               busy_d        = 1'b0;
            end
         end
         default: begin
            state_d   = ST_FILL;
            s_ready_d = 1'b1;
            busy_d    = 1'b0;
         end
      endcase
   end

`ifdef AUDIO_FRAME_CAPTURE_DROP_COUNT_EN
   always_comb begin
      drop_count_d = drop_count_q;
      if (s_valid && (!s_ready_q || (state_q == ST_FILL && flush)) && (drop_count_q != '1))
         drop_count_d = drop_count_q + CW'(1);
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_FILL;
         wr_idx_q      <= '0;
         frame_q       <= '0;
         s_ready_q     <= 1'b1;
         frame_start_q <= 1'b0;
         busy_q        <= 1'b0;
         frame_count_q <= '0;
`ifdef AUDIO_FRAME_CAPTURE_DROP_COUNT_EN
         drop_count_q  <= '0;
`endif
      end else begin
         state_q       <= state_d;
         wr_idx_q      <= wr_idx_d;
         frame_q       <= frame_d;
         s_ready_q     <= s_ready_d;
         frame_start_q <= frame_start_d;
         busy_q        <= busy_d;
         frame_count_q <= frame_count_d;
`ifdef AUDIO_FRAME_CAPTURE_DROP_COUNT_EN
         drop_count_q  <= drop_count_d;
`endif
      end
   end

   assign s_ready     = s_ready_q;
   assign frame_start = frame_start_q;
   assign busy        = busy_q;
   assign frame_data  = frame_q;
   assign frame_count = frame_count_q;
`ifdef AUDIO_FRAME_CAPTURE_DROP_COUNT_EN
   assign drop_count  = drop_count_q;
`endif

endmodule

// File: tb/tb_audio_frame_capture.sv
// Testbench for audio_frame_capture (N=4, W=32, CW=4).
// A queue-based frame model predicts every output each cycle; directed
// sequences add literal expectations for the handed-off frames.

module tb_audio_frame_capture;
   localparam int N  = 4;
   localparam int W  = 32;
   localparam int CW = 4;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           s_valid = 1'b0;
   logic [W-1:0]   s_data = '0;
   logic           flush = 1'b0;
   logic           frame_done = 1'b0;
   logic           s_ready;
   logic [N*W-1:0] frame_data;
   logic           frame_start;
   logic           busy;
   logic [CW-1:0]  frame_count;
   logic [CW-1:0]  drop_count;

   audio_frame_capture #(.N(N), .W(W), .CW(CW)) dut (
      .clk         (clk),
      .reset       (reset),
      .s_valid     (s_valid),
      .s_data      (s_data),
      .s_ready     (s_ready),
      .flush       (flush),
      .frame_data  (frame_data),
      .frame_start (frame_start),
      .frame_done  (frame_done),
      .busy        (busy),
      .frame_count (frame_count)
`ifdef AUDIO_FRAME_CAPTURE_DROP_COUNT_EN
      ,
      .drop_count  (drop_count)
`endif
   );

`ifndef AUDIO_FRAME_CAPTURE_DROP_COUNT_EN
   assign drop_count = '0;
`endif

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int n_starts = 0;

   task automatic check(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [W-1:0] slot(input int k);
      return frame_data[k*W +: W];
   endfunction

   // behavioural model: phase 0 = filling, 1 = announcing, 2 = holding
   int           m_phase = 0;
   logic [W-1:0] m_mem [N];
   logic [W-1:0] m_partial [$];
   int           m_count = 0;
   int           m_drop = 0;
   bit           m_live = 0;

   always @(posedge clk) begin
      if (reset) begin
         m_phase = 0;
         foreach (m_mem[k]) m_mem[k] = '0;
         m_partial.delete();
         m_count = 0;
         m_drop  = 0;
         m_live  = 1;
      end else begin
         if (s_valid && (m_phase != 0 || flush) && m_drop < (2**CW - 1)) m_drop++;
         case (m_phase)
            0: begin
               if (flush) m_partial.delete();
               else if (s_valid) begin
                  m_mem[m_partial.size()] = s_data;
                  m_partial.push_back(s_data);
                  if (m_partial.size() == N) begin
                     m_partial.delete();
                     m_phase = 1;
                  end
               end
            end
            1: m_phase = 2;
            default: begin
               if (frame_done) begin
                  m_count = (m_count + 1) % (2**CW);
                  m_phase = 0;
               end
            end
         endcase
      end
   end

   always @(negedge clk) begin
      if (m_live) begin
         logic [N*W-1:0] exp_vec;
         for (int k = 0; k < N; k++) exp_vec[k*W +: W] = m_mem[k];
         check("m_ready", s_ready, (m_phase == 0));
         check("m_start", frame_start, (m_phase == 1));
         check("m_busy", busy, (m_phase != 0));
         check("m_count", frame_count, m_count[CW-1:0]);
         check("m_frame", frame_data, exp_vec);
`ifdef AUDIO_FRAME_CAPTURE_DROP_COUNT_EN
         check("m_drop", drop_count, m_drop[CW-1:0]);
`endif
         if (frame_start) n_starts++;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [W-1:0] v);
      s_valid = 1'b1;
      s_data  = v;
      cyc();
   endtask

   initial begin
      cyc();
      cyc();
      check("rst_ready", s_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_start", frame_start, 0);
      check("rst_count", frame_count, 0);
      check("rst_frame", frame_data, 0);
      reset = 1'b0;

      // first frame with s_valid held high
      beat(5); beat(-3); beat(7); beat(-1);
      s_valid = 1'b0;
      check("t1_start", frame_start, 1);
      check("t1_ready", s_ready, 0);
      check("t1_busy", busy, 1);
      check("t1_s0", slot(0), 32'd5);
      check("t1_s1", slot(1), 32'hFFFF_FFFD);
      check("t1_s2", slot(2), 32'd7);
      check("t1_s3", slot(3), 32'hFFFF_FFFF);
      cyc();
      check("t1_nstart", n_starts, 1);
      repeat (10) cyc();
      check("t1_hold_s1", slot(1), 32'hFFFF_FFFD);
      check("t1_hold_nstart", n_starts, 1);
      frame_done = 1'b1; cyc(); frame_done = 1'b0;
      check("t2_count", frame_count, 1);
      check("t2_ready", s_ready, 1);

      // second frame
      beat(1); beat(2); beat(3); beat(4);
      s_valid = 1'b0;
      cyc();
      check("t2_nstart", n_starts, 2);
      frame_done = 1'b1; cyc(); frame_done = 1'b0;
      check("t2_count2", frame_count, 2);

      // flush with a same-cycle beat
      beat(11); beat(12);
      s_valid = 1'b1; s_data = 9; flush = 1'b1; cyc(); flush = 1'b0;
      beat(10); beat(20); beat(30); beat(40);
      s_valid = 1'b0;
      cyc();
      check("t3_nstart", n_starts, 3);
      check("t3_s0", slot(0), 32'd10);
      check("t3_s3", slot(3), 32'd40);

      // back-pressure while held
      s_valid = 1'b1; s_data = 99;
      for (int i = 0; i < 6; i++) begin
         cyc();
         check("t4_bp_ready", s_ready, 0);
      end
      s_valid = 1'b0;
      check("t4_s1", slot(1), 32'd20);
      check("t4_s2", slot(2), 32'd30);
`ifdef AUDIO_FRAME_CAPTURE_DROP_COUNT_EN
      check("t4_drop", drop_count, 7);
`endif
      frame_done = 1'b1; cyc(); frame_done = 1'b0;
      check("t4_count", frame_count, 3);

      // done during FILL and during HANDOFF are ignored
      beat(50);
      s_valid = 1'b0; frame_done = 1'b1; cyc(); frame_done = 1'b0;
      check("t5_count", frame_count, 3);
      beat(51); beat(52); beat(53);
      s_valid = 1'b0; frame_done = 1'b1; cyc(); frame_done = 1'b0;
      check("t5_busy", busy, 1);
      check("t5_count2", frame_count, 3);
      check("t5_nstart", n_starts, 4);
      check("t5_s0", slot(0), 32'd50);
      check("t5_s3", slot(3), 32'd53);

      // reset while holding
      reset = 1'b1; cyc(); reset = 1'b0;
      check("t6_count", frame_count, 0);
      check("t6_busy", busy, 0);
      check("t6_ready", s_ready, 1);
      check("t6_frame", frame_data, 0);
      beat(77);
      s_valid = 1'b0;
      check("t6_s0", slot(0), 32'd77);
      check("t6_s1", slot(1), 32'd0);

      // count wrap and drop saturation
      flush = 1'b1; cyc(); flush = 1'b0;
      for (int f = 0; f < 17; f++) begin
         for (int j = 0; j < N; j++) beat(32'(f * 4 + j));
         s_valid = 1'b0; cyc();
         s_valid = 1'b1; cyc(); cyc();
         s_valid = 1'b0; frame_done = 1'b1; cyc(); frame_done = 1'b0;
      end
      check("t7_wrap", frame_count, 1);
`ifdef AUDIO_FRAME_CAPTURE_DROP_COUNT_EN
      check("t7_drop_sat", drop_count, 15);
`endif
      cyc();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
